// File: rtl/reset_seq_gen.sv
// rtl/reset_seq_gen.sv - sequenced, stretched multi-channel reset generator with soft resets
module reset_seq_gen #(
    parameter int NCHAN       = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGGER     = 4,
    parameter int CNT_W       = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [NCHAN-1:0] soft_req,
    output logic [NCHAN-1:0] rst_out_n,
    output logic             busy,
    output logic             all_released
);

    localparam int IDX_W   = (NCHAN > 1) ? $clog2(NCHAN) : 1;
    localparam int MAX_CNT = (HOLD_CYCLES > STAGGER) ? HOLD_CYCLES : STAGGER;

    // Counters hold "cycles already elapsed", so the terminal value is N-1.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NCHAN - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

    // Parameter sanity: counters must never wrap.
    if (NCHAN < 1) begin : g_bad_nchan
        $error("reset_seq_gen: NCHAN must be >= 1");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("reset_seq_gen: HOLD_CYCLES must be >= 1");
    end
    if (STAGGER < 1) begin : g_bad_stagger
        $error("reset_seq_gen: STAGGER must be >= 1");
    end
    if ((64'd1 << CNT_W) <= 64'(MAX_CNT)) begin : g_bad_cnt_w
        $error("reset_seq_gen: CNT_W too small for HOLD_CYCLES/STAGGER");
    end

    typedef enum logic [1:0] {
        S_HOLD         = 2'd0,
        S_STAGGER_WAIT = 2'd1,
        S_DONE         = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] gcnt_q;
    logic [IDX_W-1:0] idx_q;
    logic [NCHAN-1:0] rst_q;
    logic             busy_q;
    logic             all_rel_q;

    // Soft-reset bookkeeping per channel. Requests are first captured in
    // req_q, which is why the channel drops one edge after the request edge.
    logic [NCHAN-1:0] req_q;
    logic [NCHAN-1:0] soft_q;
    logic [NCHAN-1:0] soft_d;
    logic [CNT_W-1:0] ch_cnt_q [NCHAN];
    logic [CNT_W-1:0] ch_cnt_d [NCHAN];

    // Next-state of each channel's soft-reset window; a fresh request restarts the count.
    always_comb begin
        soft_d = soft_q;
        for (int i = 0; i < NCHAN; i++) begin
            ch_cnt_d[i] = ch_cnt_q[i];
            if (req_q[i]) begin
                soft_d[i]   = 1'b1;
                ch_cnt_d[i] = '0;
            end else if (soft_q[i]) begin
                if (ch_cnt_q[i] == HOLD_LAST) begin
                    soft_d[i]   = 1'b0;
                    ch_cnt_d[i] = '0;
                end else begin
                    ch_cnt_d[i] = ch_cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    // Channel soft-reset registers; requests are only accepted once the global sequence is done.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            req_q  <= '0;
            soft_q <= '0;
            for (int i = 0; i < NCHAN; i++) begin
                ch_cnt_q[i] <= '0;
            end
        end else begin
            req_q  <= (state_q == S_DONE) ? soft_req : '0;
            soft_q <= soft_d;
            for (int i = 0; i < NCHAN; i++) begin
                ch_cnt_q[i] <= ch_cnt_d[i];
            end
        end
    end

    // Global release sequencer with registered outputs: hold, staggered release, then steady state.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= S_HOLD;
            gcnt_q    <= '0;
            idx_q     <= '0;
            rst_q     <= '0;
            busy_q    <= 1'b1;
            all_rel_q <= 1'b0;
        end else begin
            case (state_q)
                S_HOLD: begin
                    if (gcnt_q == HOLD_LAST) begin
                        rst_q[0] <= 1'b1;
                        gcnt_q   <= '0;
                        if (NCHAN == 1) begin
                            state_q   <= S_DONE;
                            busy_q    <= 1'b0;
                            all_rel_q <= 1'b1;
                        end else begin
                            state_q <= S_STAGGER_WAIT;
                            idx_q   <= IDX_ONE;
                        end
                    end else begin
                        gcnt_q <= gcnt_q + CNT_ONE;
                    end
                end

                S_STAGGER_WAIT: begin
                    if (gcnt_q == STAG_LAST) begin
                        for (int i = 0; i < NCHAN; i++) begin
                            if (idx_q == IDX_W'(i)) begin
                                rst_q[i] <= 1'b1;
                            end
                        end
                        gcnt_q <= '0;
                        if (idx_q == LAST_IDX) begin
                            state_q   <= S_DONE;
                            busy_q    <= 1'b0;
                            all_rel_q <= 1'b1;
                        end else begin
                            idx_q <= idx_q + IDX_ONE;
                        end
                    end else begin
                        gcnt_q <= gcnt_q + CNT_ONE;
                    end
                end

                S_DONE: begin
                    busy_q    <= 1'b0;
                    rst_q     <= ~soft_d;
                    all_rel_q <= ~(|soft_d);
                end

                default: begin
                    state_q <= S_HOLD;
                    gcnt_q  <= '0;
                    idx_q   <= '0;
                    rst_q   <= '0;
                    busy_q  <= 1'b1;
                    all_rel_q <= 1'b0;
                end
            endcase
        end
    end

    assign rst_out_n    = rst_q;
    assign busy         = busy_q;
    assign all_released = all_rel_q;

endmodule

// File: tb/tb_reset_seq_gen.sv
// tb/tb_reset_seq_gen.sv - scoreboard testbench for reset_seq_gen
module tb_reset_seq_gen;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [3:0] soft_req;
    logic [3:0] rst_out_n;
    logic       busy;
    logic       all_released;

    logic       rst1_n;
    logic [0:0] soft1;
    logic [0:0] rst1_out;
    logic       busy1;
    logic       ar1;

    always #5 CLK = ~CLK;

    reset_seq_gen #(.NCHAN(4), .HOLD_CYCLES(16), .STAGGER(4), .CNT_W(8)) u_dut (
        .CLK(CLK), .RST_N(RST_N), .soft_req(soft_req),
        .rst_out_n(rst_out_n), .busy(busy), .all_released(all_released)
    );

    reset_seq_gen #(.NCHAN(1), .HOLD_CYCLES(1), .STAGGER(1), .CNT_W(4)) u_dut1 (
        .CLK(CLK), .RST_N(rst1_n), .soft_req(soft1),
        .rst_out_n(rst1_out), .busy(busy1), .all_released(ar1)
    );

    typedef struct {
        int         cyc;
        int         unit;
        logic [3:0] rst;
        logic       bsy;
        logic       ar;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic expect_at(input int c, input int unit, input logic [3:0] r,
                             input logic b, input logic a, input string nm);
        exp_t e;
        e.cyc = c; e.unit = unit; e.rst = r; e.bsy = b; e.ar = a; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge CLK);
    endtask

    // Monitor: outputs are sampled on the falling edge, after the cycle's rising edge
    always @(negedge CLK) begin
        exp_t       e;
        logic [3:0] got_r;
        logic       got_b;
        logic       got_a;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.unit == 0) begin
                got_r = rst_out_n; got_b = busy; got_a = all_released;
            end else begin
                got_r = {3'b000, rst1_out}; got_b = busy1; got_a = ar1;
            end
            total++;
            if (e.cyc != cyc || got_r !== e.rst || got_b !== e.bsy || got_a !== e.ar) begin
                bad++;
                $display("FAIL %s cyc=%0d (want cyc %0d) got rst=%b busy=%b all_rel=%b, required rst=%b busy=%b all_rel=%b",
                         e.name, cyc, e.cyc, got_r, got_b, got_a, e.rst, e.bsy, e.ar);
            end
        end
    end

    initial begin
        int   base;
        int   p;
        int   k;
        exp_t e;

        RST_N = 1'b0; rst1_n = 1'b0; soft_req = 4'b0000; soft1 = 1'b0;

        // Scenario 1: power-on sequence
        expect_at(5, 0, 4'b0000, 1'b1, 1'b0, "s1_reset_state");
        wait_cyc(5);
        base  = cyc;
        RST_N = 1'b1;
        expect_at(base + 15, 0, 4'b0000, 1'b1, 1'b0, "s1_e15");
        expect_at(base + 16, 0, 4'b0001, 1'b1, 1'b0, "s1_e16_ch0");
        expect_at(base + 19, 0, 4'b0001, 1'b1, 1'b0, "s1_e19");
        expect_at(base + 20, 0, 4'b0011, 1'b1, 1'b0, "s1_e20_ch1");
        expect_at(base + 23, 0, 4'b0011, 1'b1, 1'b0, "s1_e23");
        expect_at(base + 24, 0, 4'b0111, 1'b1, 1'b0, "s1_e24_ch2");
        expect_at(base + 27, 0, 4'b0111, 1'b1, 1'b0, "s1_e27");
        expect_at(base + 28, 0, 4'b1111, 1'b0, 1'b1, "s1_e28_done");
        expect_at(base + 31, 0, 4'b1111, 1'b0, 1'b1, "s1_e31_steady");
        wait_cyc(base + 32);

        // Scenario 2: single-edge soft reset on channel 2
        p = cyc; k = p + 1;
        soft_req = 4'b0100;
        expect_at(k,      0, 4'b1111, 1'b0, 1'b1, "s2_k");
        expect_at(k + 1,  0, 4'b1011, 1'b0, 1'b0, "s2_k1_low");
        expect_at(k + 16, 0, 4'b1011, 1'b0, 1'b0, "s2_k16_low");
        expect_at(k + 17, 0, 4'b1111, 1'b0, 1'b1, "s2_k17_rel");
        wait_cyc(k);
        soft_req = 4'b0000;
        wait_cyc(k + 20);

        // Scenario 3: retrigger on ch1, overlapping request on ch3
        p = cyc; k = p + 1;
        soft_req = 4'b0010;
        expect_at(k + 1,  0, 4'b1101, 1'b0, 1'b0, "s3_k1_ch1");
        expect_at(k + 3,  0, 4'b0101, 1'b0, 1'b0, "s3_k3_ch3");
        expect_at(k + 17, 0, 4'b0101, 1'b0, 1'b0, "s3_k17_retrig_hold");
        expect_at(k + 18, 0, 4'b0101, 1'b0, 1'b0, "s3_k18");
        expect_at(k + 19, 0, 4'b1101, 1'b0, 1'b0, "s3_k19_ch3_rel");
        expect_at(k + 21, 0, 4'b1101, 1'b0, 1'b0, "s3_k21");
        expect_at(k + 22, 0, 4'b1111, 1'b0, 1'b1, "s3_k22_ch1_rel");
        wait_cyc(k);     soft_req = 4'b0000;
        wait_cyc(k + 1); soft_req = 4'b1000;
        wait_cyc(k + 2); soft_req = 4'b0000;
        wait_cyc(k + 4); soft_req = 4'b0010;
        wait_cyc(k + 5); soft_req = 4'b0000;
        wait_cyc(k + 25);

        // Scenario 4: reset from steady state, then reset again mid-sequence at edge 22
        p = cyc;
        RST_N = 1'b0;
        expect_at(p + 1, 0, 4'b0000, 1'b1, 1'b0, "s4_reset_from_done");
        wait_cyc(p + 2);
        base  = cyc;
        RST_N = 1'b1;
        expect_at(base + 20, 0, 4'b0011, 1'b1, 1'b0, "s4_e20");
        expect_at(base + 21, 0, 4'b0011, 1'b1, 1'b0, "s4_e21");
        expect_at(base + 22, 0, 4'b0000, 1'b1, 1'b0, "s4_e22_midreset");
        wait_cyc(base + 21);
        RST_N = 1'b0;
        wait_cyc(base + 22);

        // Scenario 5: restart with all soft requests held through the sequence
        base     = cyc;
        RST_N    = 1'b1;
        soft_req = 4'b1111;
        expect_at(base + 15, 0, 4'b0000, 1'b1, 1'b0, "s5_e15");
        expect_at(base + 16, 0, 4'b0001, 1'b1, 1'b0, "s5_e16");
        expect_at(base + 20, 0, 4'b0011, 1'b1, 1'b0, "s5_e20");
        expect_at(base + 24, 0, 4'b0111, 1'b1, 1'b0, "s5_e24");
        expect_at(base + 27, 0, 4'b0111, 1'b1, 1'b0, "s5_e27");
        expect_at(base + 28, 0, 4'b1111, 1'b0, 1'b1, "s5_e28_done");
        expect_at(base + 29, 0, 4'b1111, 1'b0, 1'b1, "s5_e29_first_sample");
        expect_at(base + 30, 0, 4'b0000, 1'b0, 1'b0, "s5_e30_all_soft");
        expect_at(base + 45, 0, 4'b0000, 1'b0, 1'b0, "s5_e45");
        expect_at(base + 46, 0, 4'b1111, 1'b0, 1'b1, "s5_e46_rel");
        wait_cyc(base + 29);
        soft_req = 4'b0000;
        wait_cyc(base + 50);

        // Scenario 6: NCHAN=1, HOLD_CYCLES=1 corner instance
        p = cyc;
        expect_at(p,     1, 4'b0000, 1'b1, 1'b0, "s6_reset_state");
        expect_at(p + 1, 1, 4'b0001, 1'b0, 1'b1, "s6_e1_release");
        rst1_n = 1'b1;
        wait_cyc(p + 3);
        soft1 = 1'b1;
        k = p + 4;
        expect_at(k,     1, 4'b0001, 1'b0, 1'b1, "s6_k");
        expect_at(k + 1, 1, 4'b0000, 1'b0, 1'b0, "s6_k1_low");
        expect_at(k + 2, 1, 4'b0001, 1'b0, 1'b1, "s6_k2_rel");
        expect_at(k + 3, 1, 4'b0001, 1'b0, 1'b1, "s6_k3_steady");
        wait_cyc(k);
        soft1 = 1'b0;
        wait_cyc(k + 5);

        total++;
        if (rst_out_n !== 4'b1111 || busy !== 1'b0 || all_released !== 1'b1) begin
            bad++;
            $display("FAIL final_dut_steady got rst=%b busy=%b all_rel=%b", rst_out_n, busy, all_released);
        end
        total++;
        if (rst1_out !== 1'b1 || busy1 !== 1'b0 || ar1 !== 1'b1) begin
            bad++;
            $display("FAIL final_dut1_steady got rst=%b busy=%b all_rel=%b", rst1_out, busy1, ar1);
        end

        for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge CLK);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            bad++;
            $display("FAIL %s never checked (want cyc %0d, now cyc %0d)", e.name, e.cyc, cyc);
        end

        if (bad == 0 && total >= 12) begin
            $display("PASS");
        end else begin
            $display("FAIL summary");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
